// File: rtl/bist_seq.sv
`default_nettype none
// ============================================================================
// Module      : bist_seq
// Description : Memory BIST initiator. Runs the attached engines through a
//               march pass, then a force-one and a force-zero self-check pass.
//               Reports sticky pass / fail / check-error / timeout status.
// Revision    : 1.0 - initial release
// ============================================================================
module bist_seq #(
  parameter int NUM_ENG = 2,
  parameter int TO_W    = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 skip_chk,
  output logic                 bist_go,
  output logic                 bist_check,
  input  logic [NUM_ENG-1:0]   eng_done,
  input  logic [4*NUM_ENG-1:0] eng_fail,
  output logic                 busy,
  output logic                 seq_done,
  output logic                 pass,
  output logic [4*NUM_ENG-1:0] fail_vec,
  output logic [4*NUM_ENG-1:0] chk_err,
  output logic                 timeout
);

  localparam int FW = 4 * NUM_ENG;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GO   = 3'd1;
  localparam logic [2:0] S_GAP0 = 3'd2;
  localparam logic [2:0] S_CHK0 = 3'd3;
  localparam logic [2:0] S_CHK1 = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  logic [2:0]         state_q,    state_d;
  logic               go_q,       go_d;
  logic               check_q,    check_d;
  logic [NUM_ENG-1:0] done_cap_q, done_cap_d;
  logic [TO_W-1:0]    timer_q,    timer_d;
  logic [FW-1:0]      fail_vec_q, fail_vec_d;
  logic [FW-1:0]      seen0_q,    seen0_d;
  logic [FW-1:0]      seen1_q,    seen1_d;
  logic [FW-1:0]      chk_err_q,  chk_err_d;
  logic               pass_q,     pass_d;
  logic               timeout_q,  timeout_d;
  logic               skip_q,     skip_d;

  logic               timer_exp;
  logic               all_done;

  // Next-state and sticky-status logic; done/fail seen on a transition edge
  // still belong to the phase being left.
  always_comb begin
    state_d    = state_q;
    done_cap_d = done_cap_q;
    timer_d    = timer_q;
    fail_vec_d = fail_vec_q;
    seen0_d    = seen0_q;
    seen1_d    = seen1_q;
    chk_err_d  = chk_err_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    skip_d     = skip_q;
    timer_exp  = &timer_q;
    all_done   = &done_cap_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_GO;
          fail_vec_d = '0;
          chk_err_d  = '0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          skip_d     = skip_chk;
          done_cap_d = '0;
          timer_d    = '0;
          seen0_d    = '0;
          seen1_d    = '0;
        end
      end
      S_GO: begin
        done_cap_d = done_cap_q | eng_done;
        fail_vec_d = fail_vec_q | eng_fail;
        timer_d    = timer_q + TO_W'(1);
        if (timer_exp) begin
          timeout_d = 1'b1;
          state_d   = S_FIN;
        end else if (all_done) begin
          state_d = skip_q ? S_FIN : S_GAP0;
        end
      end
      S_GAP0: begin
        done_cap_d = '0;
        seen0_d    = '0;
        seen1_d    = '0;
        timer_d    = '0;
        state_d    = S_CHK0;
      end
      S_CHK0: begin
        done_cap_d = done_cap_q | eng_done;
        seen0_d    = seen0_q | eng_fail;
        timer_d    = timer_q + TO_W'(1);
        if (timer_exp) begin
          timeout_d = 1'b1;
          state_d   = S_FIN;
        end else if (all_done) begin
          state_d    = S_CHK1;
          done_cap_d = '0;
          timer_d    = '0;
        end
      end
      S_CHK1: begin
        done_cap_d = done_cap_q | eng_done;
        seen1_d    = seen1_q | eng_fail;
        timer_d    = timer_q + TO_W'(1);
        if (timer_exp) begin
          timeout_d = 1'b1;
          state_d   = S_FIN;
        end else if (all_done) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Result is resolved on the edge into FIN so it is valid with seq_done.
    if ((state_d == S_FIN) && (state_q != S_FIN)) begin
      chk_err_d = skip_q ? '0 : ~(seen0_d & seen1_d);
      pass_d    = (fail_vec_d == '0) && (chk_err_d == '0) && !timeout_d;
    end

    go_d    = (state_d == S_GO);
    check_d = (state_d == S_CHK0);
  end

  // State and status registers; reset drops the engine controls immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      go_q       <= 1'b0;
      check_q    <= 1'b0;
      done_cap_q <= '0;
      timer_q    <= '0;
      fail_vec_q <= '0;
      seen0_q    <= '0;
      seen1_q    <= '0;
      chk_err_q  <= '0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      skip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      go_q       <= go_d;
      check_q    <= check_d;
      done_cap_q <= done_cap_d;
      timer_q    <= timer_d;
      fail_vec_q <= fail_vec_d;
      seen0_q    <= seen0_d;
      seen1_q    <= seen1_d;
      chk_err_q  <= chk_err_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      skip_q     <= skip_d;
    end
  end

  assign bist_go    = go_q;
  assign bist_check = check_q;
  assign busy       = (state_q != S_IDLE);
  assign seq_done   = (state_q == S_FIN);
  assign pass       = pass_q;
  assign fail_vec   = fail_vec_q;
  assign chk_err    = chk_err_q;
  assign timeout    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_bist_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bist_seq
// Description : Self-checking bench for bist_seq with two reactive engine
//               models and a cycle-level behavioural reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bist_seq;

  localparam int NUM_ENG = 2;
  localparam int TO_W    = 6;
  localparam int LIMIT   = (1 << TO_W) - 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       skip_chk = 1'b0;
  logic       bist_go, bist_check, busy, seq_done, pass, timeout;
  logic [1:0] eng_done = '0;
  logic [7:0] eng_fail = '0;
  logic [7:0] fail_vec, chk_err;

  int checks = 0;
  int failures = 0;

  bist_seq #(.NUM_ENG(NUM_ENG), .TO_W(TO_W)) dut (
    .clk(clk), .reset(reset), .start(start), .skip_chk(skip_chk),
    .bist_go(bist_go), .bist_check(bist_check),
    .eng_done(eng_done), .eng_fail(eng_fail),
    .busy(busy), .seq_done(seq_done), .pass(pass),
    .fail_vec(fail_vec), .chk_err(chk_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (phase-level view) ----------------
  localparam int ST_IDLE = 0, ST_MARCH = 1, ST_GAP = 2, ST_HI = 3, ST_LO = 4, ST_FIN = 5;
  int       m_stage = ST_IDLE;
  int       m_timer = 0;
  bit [1:0] m_done;
  bit [7:0] m_fail, m_s0, m_s1, m_chk;
  bit       m_pass, m_to, m_skip;

  task automatic model_step();
    int nxt;
    bit finished, expired;
    if (reset) begin
      m_stage = ST_IDLE; m_timer = 0; m_done = 0; m_fail = 0; m_s0 = 0; m_s1 = 0;
      m_chk = 0; m_pass = 0; m_to = 0; m_skip = 0;
      return;
    end
    nxt = m_stage;
    case (m_stage)
      ST_IDLE: if (start) begin
        nxt = ST_MARCH; m_fail = 0; m_chk = 0; m_pass = 0; m_to = 0;
        m_skip = skip_chk; m_done = 0; m_timer = 0; m_s0 = 0; m_s1 = 0;
      end
      ST_MARCH, ST_HI, ST_LO: begin
        finished = ($countones(m_done) == NUM_ENG);
        expired  = (m_timer == LIMIT);
        if (m_stage == ST_MARCH) m_fail |= eng_fail;
        else if (m_stage == ST_HI) m_s0 |= eng_fail;
        else m_s1 |= eng_fail;
        m_done |= eng_done;
        m_timer++;
        if (expired) begin
          m_to = 1; nxt = ST_FIN;
        end else if (finished) begin
          if (m_stage == ST_MARCH) nxt = m_skip ? ST_FIN : ST_GAP;
          else if (m_stage == ST_HI) begin nxt = ST_LO; m_done = 0; m_timer = 0; end
          else nxt = ST_FIN;
        end
      end
      ST_GAP: begin m_done = 0; m_s0 = 0; m_s1 = 0; m_timer = 0; nxt = ST_HI; end
      default: nxt = ST_IDLE;
    endcase
    if (nxt == ST_FIN && m_stage != ST_FIN) begin
      m_chk  = m_skip ? 8'h00 : ~(m_s0 & m_s1);
      m_pass = (m_fail == 0) && (m_chk == 0) && !m_to;
    end
    m_stage = nxt;
  endtask

  // ---------------- engine models ----------------
  int       dly [2] = '{37, 40};
  bit [7:0] go_mask, c0_mask, c1_mask;
  bit [1:0] nodone_go;
  int       e_kind = 0;   // 0 idle, 1 march, 2 check-high, 3 check-low
  int       e_pc = 0;
  logic     prev_go = 1'b0, prev_chk = 1'b0;

  task automatic engine_step(input bit rst_seen);
    bit [7:0] m;
    eng_done = '0;
    eng_fail = '0;
    if (rst_seen) begin
      e_kind = 0; prev_go = bist_go; prev_chk = bist_check;
      return;
    end
    if (bist_go && !prev_go) begin e_kind = 1; e_pc = 0; end
    else if (bist_check && !prev_chk) begin e_kind = 2; e_pc = 0; end
    else if (!bist_check && prev_chk) begin e_kind = 3; e_pc = 0; end
    else if (e_kind != 0) begin
      e_pc++;
      if (e_pc > 100) e_kind = 0;
    end
    prev_go = bist_go; prev_chk = bist_check;
    if (e_kind != 0 && e_pc > 0) begin
      m = (e_kind == 1) ? go_mask : (e_kind == 2) ? c0_mask : c1_mask;
      if (e_pc == 5) eng_fail = m;
      for (int e = 0; e < NUM_ENG; e++)
        if (e_pc == dly[e] && !(e_kind == 1 && nodone_go[e])) eng_done[e] = 1'b1;
    end
  endtask

  // ---------------- cycle driver ----------------
  int cyc = 0, go_hi = 0, chk_hi = 0, done_cnt = 0, done_cyc = 0, last_done_cyc = 0;
  bit chk_en = 0;

  task automatic tick();
    bit r;
    @(posedge clk);
    r = reset;
    model_step();
    #1;
    cyc++;
    if (bist_go === 1'b1) go_hi++;
    if (bist_check === 1'b1) chk_hi++;
    if (seq_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    engine_step(r);
    if (eng_done != 0) last_done_cyc = cyc;
  endtask

  // Cycle-by-cycle comparison against the reference model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("bist_go",    bist_go,    m_stage == ST_MARCH);
      check("bist_check", bist_check, m_stage == ST_HI);
      check("busy",       busy,       m_stage != ST_IDLE);
      check("seq_done",   seq_done,   m_stage == ST_FIN);
      check("pass",       pass,       m_pass);
      check("fail_vec",   fail_vec,   m_fail);
      check("chk_err",    chk_err,    m_chk);
      check("timeout",    timeout,    m_to);
    end
  end

  task automatic launch(input bit skip, input bit [7:0] gm, input bit [7:0] c0m,
                        input bit [7:0] c1m, input bit [1:0] nd);
    go_mask = gm; c0_mask = c0m; c1_mask = c1m; nodone_go = nd;
    go_hi = 0; chk_hi = 0; done_cnt = 0;
    start = 1'b1; skip_chk = skip;
    tick();
    start = 1'b0; skip_chk = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (seq_done === 1'b1) begin ok = 1; break; end
    end
    if (!ok) check({name, "_seq_done_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tick();
    chk_en = 1;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_go", bist_go, 0);
    check("rst_status", {pass, timeout, fail_vec, chk_err}, 0);
    tick(); tick();

    // 1: clean run, all banks flag in both check phases
    launch(0, 8'h00, 8'hFF, 8'hFF, 2'b00);
    wait_done("clean");
    check("clean_pass", pass, 1);
    check("clean_fail_vec", fail_vec, 8'h00);
    check("clean_chk_err", chk_err, 8'h00);
    check("clean_go_cycles", go_hi, 42);
    check("clean_chk_cycles", chk_hi, 42);
    tick();
    check("clean_back_idle", busy, 0);
    for (int i = 0; i < 5; i++) tick();

    // 2: march fail on engine 1 bank 2
    launch(0, 8'h40, 8'hFF, 8'hFF, 2'b00);
    wait_done("marchfail");
    check("marchfail_fail_vec", fail_vec, 8'h40);
    check("marchfail_pass", pass, 0);
    check("marchfail_chk_err", chk_err, 8'h00);
    for (int i = 0; i < 5; i++) tick();

    // 3: engine 0 bank 0 silent in the force-zero check
    launch(0, 8'h00, 8'hFF, 8'hFE, 2'b00);
    wait_done("chkerr");
    check("chkerr_chk_err", chk_err, 8'h01);
    check("chkerr_pass", pass, 0);
    for (int i = 0; i < 5; i++) tick();

    // 4: engine 1 never completes the march -> timeout
    launch(0, 8'h00, 8'hFF, 8'hFF, 2'b10);
    wait_done("timeout");
    check("timeout_flag", timeout, 1);
    check("timeout_pass", pass, 0);
    check("timeout_go_cycles", go_hi, LIMIT + 1);
    check("timeout_chk_cycles", chk_hi, 0);
    for (int i = 0; i < 10; i++) tick();
    check("timeout_go_after", bist_go, 0);
    check("timeout_chk_after", bist_check, 0);

    // 5: march only
    launch(1, 8'h00, 8'hFF, 8'hFF, 2'b00);
    wait_done("skip");
    check("skip_latency", done_cyc - last_done_cyc, 2);
    check("skip_chk_cycles", chk_hi, 0);
    check("skip_chk_err", chk_err, 8'h00);
    check("skip_pass", pass, 1);
    for (int i = 0; i < 5; i++) tick();

    // 6: reset in the middle of CHK0
    launch(0, 8'h40, 8'hFF, 8'hFF, 2'b00);
    for (int i = 0; i < 200 && bist_check !== 1'b1; i++) tick();
    check("rstmid_reached_chk0", bist_check, 1);
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_check", bist_check, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_status", {pass, timeout, fail_vec, chk_err}, 0);
    for (int i = 0; i < 5; i++) tick();

    // 7: start while busy is ignored
    launch(0, 8'h00, 8'hFF, 8'hFF, 2'b00);
    for (int i = 0; i < 10; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ignore");
    for (int i = 0; i < 80; i++) tick();
    check("ignore_one_done", done_cnt, 1);
    check("ignore_idle", busy, 0);
    check("ignore_pass", pass, 1);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
